mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words (power of two, 4..1024).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  access request from the multicycle core, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; captured with req.
REQ-007 SHALL have port adr  input  32  byte address; word index = adr[log2(DEPTH_WORDS)+1:2].
REQ-008 SHALL have port wdata  input  32  write data; captured with req.
REQ-009 SHALL have port ready  output  1  one-cycle pulse marking access completion.
REQ-010 SHALL have port rdata  output  32  registered read data, valid while ready=1, held afterwards.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port err  output  1  access error flag (present only under MEMRESP_ERR_EN).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: req=1 at an edge SHALL capture we/adr/wdata, load counter with WAIT_CYCLES, go to WAIT (or to RESP if WAIT_CYCLES=0).
REQ-015 WAIT: counter SHALL decrement each edge; on edge where counter=1 go to RESP.
REQ-016 RESP SHALL last exactly one cycle, drive ready=1, then return to IDLE.
REQ-017 Latency: ready SHALL be high in the cycle after WAIT_CYCLES+1 edges following acceptance; throughput one access per WAIT_CYCLES+2 cycles.
REQ-018 Write SHALL commit to the array on the edge entering RESP, using captured values only.
REQ-019 Read SHALL load rdata on the edge entering RESP; rdata SHALL hold until the next read response; writes SHALL not alter rdata.
REQ-020 req/we/adr/wdata changes during WAIT or RESP SHALL be ignored; req high in RESP SHALL not be accepted until IDLE.
REQ-021 Read of a word written by the immediately preceding access SHALL return the new value.
REQ-022 Address bits above the index and adr[1:0] SHALL be ignored (address wraps modulo DEPTH_WORDS*4) when MEMRESP_ERR_EN undefined.

Reset
REQ-023 reset SHALL force state=IDLE, counter=0, ready=0, busy=0, rdata=0, err=0 immediately, independent of clk.
REQ-024 Reset mid-access SHALL abort it; an uncommitted write SHALL not occur; array contents SHALL not be cleared.

Configuration
REQ-025 Macro MEMRESP_ERR_EN SHALL, when defined, add port err: access with adr[1:0]!=0 or adr >= DEPTH_WORDS*4 completes normally in timing, suppresses the write, sets rdata=0, and drives err=1 together with ready.
REQ-026 Without MEMRESP_ERR_EN, port err SHALL be absent and REQ-022 applies.

Structure
REQ-027 Package memresp_pkg SHALL hold the state typedef (2-bit: IDLE=0, WAIT=1, RESP=2) and word-width constant 32.
REQ-028 Word array SHALL be a sub-module mem_responder_ram (synchronous write, combinational read, no reset).

Verification
REQ-029 Write adr=0x10 wdata=0xDEADBEEF, WAIT_CYCLES=2 -> ready pulses exactly 3 cycles after acceptance edge; subsequent read 0x10 returns 0xDEADBEEF.
REQ-030 WAIT_CYCLES=0, read 0x0 after writing 0x12345678 -> ready one cycle after acceptance, rdata=0x12345678, busy high one cycle.
REQ-031 req held high continuously, 3 reads -> accepted every WAIT_CYCLES+2 cycles; mid-access adr toggling has no effect.
REQ-032 Write 0x4 = 0xAAAA5555, assert reset during WAIT -> all outputs 0 immediately; read 0x4 returns prior contents, not 0xAAAA5555.
REQ-033 DEPTH_WORDS=64, write adr=0x104 (no macro) -> lands in word 1; with MEMRESP_ERR_EN, adr=0x104 or 0x6 -> err=1 with ready, rdata=0, array unchanged.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the wait-state memory responder.
package memresp_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // True when a byte address is word aligned and inside a depth-word array.
  function automatic logic adr_in_range(input logic [31:0] adr, input int depth);
    return (adr[1:0] == 2'b00) && (adr < 32'(depth * 4));
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Word array for mem_responder: synchronous write, combinational read, no reset.
module mem_responder_ram
  import memresp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr_i,
  input  word_t                          wdata_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr_i,
  output word_t                          rdata_o
);

  word_t mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: IDLE -> WAIT (WAIT_CYCLES edges) -> RESP, one access at a time.
// Define MEMRESP_ERR_EN to add the err port and misaligned/out-of-range access checking.
module mem_responder
  import memresp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        busy
`ifdef MEMRESP_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] adr_q;
  word_t       wdata_q;
  word_t       rdata_q, rdata_d;

  logic        enter_resp;
  logic        from_idle;
  logic        acc_we;
  logic [31:0] acc_adr;
  word_t       acc_wdata;
  logic        acc_bad;
  logic [AW-1:0] acc_idx;
  logic        ram_we;
  word_t       ram_rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states RESP is entered on the acceptance edge itself, so
  // the access is taken straight from the inputs being captured on that edge.
  assign from_idle = (state_q == IDLE);
  assign acc_we    = from_idle ? we    : we_q;
  assign acc_adr   = from_idle ? adr   : adr_q;
  assign acc_wdata = from_idle ? wdata : wdata_q;
  assign acc_idx   = acc_adr[AW+1:2];

`ifdef MEMRESP_ERR_EN
  assign acc_bad = !adr_in_range(acc_adr, DEPTH_WORDS);
`else
  logic unused_adr_bits;
  assign unused_adr_bits = ^{acc_adr[31:AW+2], acc_adr[1:0]};
  assign acc_bad = 1'b0;
`endif

  assign ram_we = enter_resp & acc_we & ~acc_bad;

  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp && (!acc_we || acc_bad)) begin
      rdata_d = acc_bad ? '0 : ram_rdata;
    end
  end

  mem_responder_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (acc_idx),
    .wdata_i (acc_wdata),
    .raddr_i (acc_idx),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request fields are only latched on acceptance; later changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
    end else if (from_idle && req) begin
      we_q    <= we;
      adr_q   <= adr;
      wdata_q <= wdata;
    end
  end

`ifdef MEMRESP_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (enter_resp) begin
      err_d = acc_bad;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q & ready;
`endif

  assign ready = (state_q == RESP);
  assign busy  = (state_q != IDLE);
  assign rdata = rdata_q;

endmodule
